// File: rtl/ofmd_maxpool_reader_if.sv
// Bundles the OFMD RAM read port and the pooled-output valid/ready stream.
// master: the pooling reader; slave: the RAM plus the downstream consumer.
interface ofmd_maxpool_reader_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
);
    logic              ofmd_read;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] ofmd_data;
    logic              pool_valid;
    logic              pool_ready;
    logic [DATA_W-1:0] pool_data;
    logic [3:0]        pool_idx;

    modport master (
        output ofmd_read,
        output read_addr,
        input  ofmd_data,
        output pool_valid,
        input  pool_ready,
        output pool_data,
        output pool_idx
    );

    modport slave (
        input  ofmd_read,
        input  read_addr,
        output ofmd_data,
        input  pool_valid,
        output pool_ready,
        input  pool_data,
        input  pool_idx
    );
endinterface

// File: rtl/ofmd_maxpool_reader.sv
// Walks the output feature map in 2x2 non-overlapping windows, reads each window
// through the registered RAM port, and streams the unsigned window maxima out.
module ofmd_maxpool_reader #(
    parameter int unsigned MAP_W  = 8,
    parameter int unsigned MAP_H  = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    ofmd_maxpool_reader_if.master bus
);

    localparam int unsigned PoolW = MAP_W / 2;
    localparam int unsigned PoolH = MAP_H / 2;
    localparam logic [3:0]  PcLast = 4'(PoolW - 1);
    localparam logic [3:0]  KLast  = 4'(PoolW * PoolH - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRd   = 3'd1;
    localparam logic [2:0] StLast = 3'd2;
    localparam logic [2:0] StOut  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    logic [2:0]        state_q;
    logic [1:0]        rd_cnt_q;
    logic [3:0]        k_q;
    logic [3:0]        pr_q;
    logic [3:0]        pc_q;
    logic [DATA_W-1:0] max_q;
    logic [ADDR_W-1:0] read_addr_q;
    logic              pool_valid_q;
    logic [DATA_W-1:0] pool_data_q;
    logic [3:0]        pool_idx_q;
    logic              busy_q;

    logic [3:0]        pr_nxt;
    logic [3:0]        pc_nxt;
    logic [ADDR_W-1:0] base_cur;
    logic [ADDR_W-1:0] base_nxt;
    logic [ADDR_W-1:0] addr_step;
    logic [DATA_W-1:0] max_in;

    // Top-left address of the window at pooled row pr, pooled column pc.
    function automatic logic [ADDR_W-1:0] win_base(input logic [3:0] pr, input logic [3:0] pc);
        return ADDR_W'(2 * MAP_W * int'(pr) + 2 * int'(pc));
    endfunction

    // Offsets within a window in read order: TL, TR, BL, BR.
    function automatic logic [ADDR_W-1:0] win_off(input logic [1:0] idx);
        logic [ADDR_W-1:0] off;
        case (idx)
            2'd0:    off = '0;
            2'd1:    off = ADDR_W'(1);
            2'd2:    off = ADDR_W'(MAP_W);
            default: off = ADDR_W'(MAP_W + 1);
        endcase
        return off;
    endfunction

    // Window addressing for the current read and for the next window.
    always_comb begin
        pc_nxt    = (pc_q == PcLast) ? 4'd0 : pc_q + 4'd1;
        pr_nxt    = (pc_q == PcLast) ? pr_q + 4'd1 : pr_q;
        base_cur  = win_base(pr_q, pc_q);
        base_nxt  = win_base(pr_nxt, pc_nxt);
        addr_step = base_cur + win_off(rd_cnt_q + 2'd1);
        max_in    = (bus.ofmd_data > max_q) ? bus.ofmd_data : max_q;
    end

    // Sequencer and datapath; read_addr is pre-loaded so it is valid throughout RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rd_cnt_q     <= 2'd0;
            k_q          <= 4'd0;
            pr_q         <= 4'd0;
            pc_q         <= 4'd0;
            max_q        <= '0;
            read_addr_q  <= '0;
            pool_valid_q <= 1'b0;
            pool_data_q  <= '0;
            pool_idx_q   <= 4'd0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StRd;
                        k_q         <= 4'd0;
                        pr_q        <= 4'd0;
                        pc_q        <= 4'd0;
                        rd_cnt_q    <= 2'd0;
                        read_addr_q <= win_base(4'd0, 4'd0);
                        busy_q      <= 1'b1;
                    end
                end
                StRd: begin
                    // Data for read n arrives while read n+1 is being issued.
                    if (rd_cnt_q == 2'd1) begin
                        max_q <= bus.ofmd_data;
                    end else if (rd_cnt_q != 2'd0) begin
                        max_q <= max_in;
                    end
                    if (rd_cnt_q == 2'd3) begin
                        state_q <= StLast;
                    end else begin
                        rd_cnt_q    <= rd_cnt_q + 2'd1;
                        read_addr_q <= addr_step;
                    end
                end
                StLast: begin
                    pool_data_q  <= max_in;
                    pool_idx_q   <= k_q;
                    pool_valid_q <= 1'b1;
                    state_q      <= StOut;
                end
                StOut: begin
                    if (bus.pool_ready) begin
                        pool_valid_q <= 1'b0;
                        if (k_q == KLast) begin
                            state_q <= StDone;
                        end else begin
                            k_q         <= k_q + 4'd1;
                            pr_q        <= pr_nxt;
                            pc_q        <= pc_nxt;
                            rd_cnt_q    <= 2'd0;
                            read_addr_q <= base_nxt;
                            state_q     <= StRd;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ofmd_read  = (state_q == StRd);
    assign bus.read_addr  = read_addr_q;
    assign bus.pool_valid = pool_valid_q;
    assign bus.pool_data  = pool_data_q;
    assign bus.pool_idx   = pool_idx_q;
    assign busy           = busy_q;
    assign done           = (state_q == StDone);

endmodule

// File: tb/tb_ofmd_maxpool_reader.sv
// Bench for ofmd_maxpool_reader: RAM model, window-max reference model, directed passes.
module tb_ofmd_maxpool_reader;

    localparam int W = 8;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    ofmd_maxpool_reader_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    ofmd_maxpool_reader #(
        .MAP_W (W),
        .MAP_H (H),
        .ADDR_W(6),
        .DATA_W(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // RAM with registered read port
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (bus.ofmd_read) bus.ofmd_data <= mem[bus.read_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: expected outputs and read-address sequence for the whole pass
    int exp_out [16];
    int exp_addr [64];

    task automatic build_model();
        int offs [4];
        offs[0] = 0; offs[1] = 1; offs[2] = W; offs[3] = W + 1;
        for (int k = 0; k < 16; k++) begin
            int pr, pc, base, m;
            pr = k / (W / 2);
            pc = k % (W / 2);
            base = 2 * pr * W + 2 * pc;
            m = 0;
            for (int i = 0; i < 4; i++) begin
                exp_addr[4 * k + i] = base + offs[i];
                if (int'(mem[base + offs[i]]) > m) m = int'(mem[base + offs[i]]);
            end
            exp_out[k] = m;
        end
    endtask

    // Monitor state
    int cyc = 0;
    bit mon_en = 0;
    int rd_ptr, out_ptr, done_cnt;
    int t0, first_rd, first_valid, done_cyc;
    logic busy_at_done, busy_after;
    int cap [16];
    int addr_log [8];

    // Single compare process: checks every read address and every accepted output
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (start && !busy && t0 < 0) t0 = cyc;
            if (bus.ofmd_read) begin
                if (first_rd < 0) first_rd = cyc;
                chk("no_read_while_valid", {31'd0, bus.pool_valid}, 0);
                if (rd_ptr < 64) chk("read_addr", {26'd0, bus.read_addr}, exp_addr[rd_ptr]);
                else chk("extra_read", rd_ptr, 63);
                if (rd_ptr < 8) addr_log[rd_ptr] = int'(bus.read_addr);
                rd_ptr++;
            end
            if (bus.pool_valid && first_valid < 0) first_valid = cyc;
            if (bus.pool_valid && bus.pool_ready) begin
                if (out_ptr < 16) begin
                    chk("pool_idx", {28'd0, bus.pool_idx}, out_ptr);
                    chk("pool_data", {24'd0, bus.pool_data}, exp_out[out_ptr]);
                    cap[out_ptr] = int'(bus.pool_data);
                end else begin
                    chk("extra_output", out_ptr, 15);
                end
                out_ptr++;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic begin_pass();
        build_model();
        rd_ptr = 0; out_ptr = 0; done_cnt = 0;
        t0 = -1; first_rd = -1; first_valid = -1; done_cyc = -1;
        busy_at_done = 1'bx; busy_after = 1'bx;
        for (int i = 0; i < 16; i++) cap[i] = -1;
        mon_en = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_pass();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done_cnt > 0}, 1);
        repeat (4) @(negedge clk);
        chk("output_count", out_ptr, 16);
        chk("done_count", done_cnt, 1);
        chk("read_count", rd_ptr, 64);
        mon_en = 0;
    endtask

    task automatic wait_idx(input logic [3:0] idx);
        bit found;
        found = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(posedge clk); #1;
            if (bus.pool_valid && bus.pool_idx == idx) found = 1;
        end
        chk("reached_idx", {31'd0, found}, 1);
    endtask

    int asc_lit [16] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.pool_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ofmd_read", {31'd0, bus.ofmd_read}, 0);
        chk("rst_read_addr", {26'd0, bus.read_addr}, 0);
        chk("rst_pool_valid", {31'd0, bus.pool_valid}, 0);
        chk("rst_pool_data", {24'd0, bus.pool_data}, 0);
        chk("rst_pool_idx", {28'd0, bus.pool_idx}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Ascending map with ready held high, plus latency checks
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
        build_model();
        chk("model_pin_k0", exp_out[0], 9);
        chk("model_pin_k15", exp_out[15], 63);
        begin_pass();
        finish_pass();
        for (int k = 0; k < 16; k++) chk("asc_literal", cap[k], asc_lit[k]);
        chk("first_read_latency", first_rd - t0, 1);
        chk("first_valid_latency", first_valid - t0, 6);
        chk("done_latency", done_cyc - t0, 97);
        chk("busy_at_done", {31'd0, busy_at_done}, 1);
        chk("busy_after_done", {31'd0, busy_after}, 0);

        // Descending map: max is always the window's top-left entry
        for (int a = 0; a < 64; a++) mem[a] = 8'(63 - a);
        begin_pass();
        finish_pass();
        chk("desc_k0", cap[0], 63);
        chk("desc_k5", cap[5], 45);
        chk("desc_k15", cap[15], 9);
        chk("desc_addr0", addr_log[0], 0);
        chk("desc_addr1", addr_log[1], 1);
        chk("desc_addr2", addr_log[2], 8);
        chk("desc_addr3", addr_log[3], 9);

        // Backpressure: stall 10 cycles while window 5 is presented
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
        begin_pass();
        wait_idx(4'd5);
        bus.pool_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, bus.pool_valid}, 1);
            chk("stall_data", {24'd0, bus.pool_data}, 27);
            chk("stall_idx", {28'd0, bus.pool_idx}, 5);
            chk("stall_no_read", {31'd0, bus.ofmd_read}, 0);
        end
        @(posedge clk); #1 bus.pool_ready = 1'b1;
        finish_pass();
        chk("stall_k6", cap[6], 29);

        // Full scale ties
        for (int a = 0; a < 64; a++) mem[a] = 8'd255;
        begin_pass();
        finish_pass();
        for (int k = 0; k < 16; k++) chk("all_255", cap[k], 255);

        // Single non-zero entry at the bottom-right of window 5
        for (int a = 0; a < 64; a++) mem[a] = 8'd0;
        mem[27] = 8'd200;
        begin_pass();
        finish_pass();
        chk("br_only_k5", cap[5], 200);
        chk("br_only_k4", cap[4], 0);
        chk("br_only_k6", cap[6], 0);

        // Reset mid-pass while window 7 is presented
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
        begin_pass();
        wait_idx(4'd7);
        mon_en = 0;
        rst = 1'b1;
        #1;
        chk("midrst_ofmd_read", {31'd0, bus.ofmd_read}, 0);
        chk("midrst_read_addr", {26'd0, bus.read_addr}, 0);
        chk("midrst_pool_valid", {31'd0, bus.pool_valid}, 0);
        chk("midrst_pool_data", {24'd0, bus.pool_data}, 0);
        chk("midrst_pool_idx", {28'd0, bus.pool_idx}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_no_done_seen", done_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_idle_busy", {31'd0, busy}, 0);
        chk("post_rst_idle_done", {31'd0, done}, 0);
        begin_pass();
        finish_pass();
        chk("post_rst_k0", cap[0], 9);

        // Start pulses while busy must be ignored
        begin_pass();
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (39) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_pass();
        chk("busy_start_done_latency", done_cyc - t0, 97);
        repeat (120) @(negedge clk);
        chk("busy_start_no_restart", {31'd0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ofmd_maxpool_reader.md
# ofmd_maxpool_reader

Downstream consumer of the output-feature-map RAM (64 x 8-bit, registered read port). After the convolution engine has filled the 8x8 output map, this block walks it in 2x2 non-overlapping windows, issues four RAM reads per window, computes the unsigned maximum, and delivers 16 pooled bytes (4x4 map) over a valid/ready handshake to the next stage. It owns the RAM read port (read enable and read address) for the whole pass.

## Interface
- MAP_W, 8, input map width (pooled width = MAP_W/2)
- MAP_H, 8, input map height (pooled height = MAP_H/2)
- ADDR_W, 6, RAM address width (2^ADDR_W >= MAP_W*MAP_H)
- DATA_W, 8, feature data width, unsigned
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse, begins a pass; ignored while busy
- ofmd_read  out  1  RAM read enable
- read_addr  out  ADDR_W  RAM read address
- ofmd_data  in  DATA_W  RAM read data, valid the cycle after ofmd_read
- pool_valid  out  1  pool_data/pool_idx valid
- pool_ready  in  1  consumer accepts when pool_valid && pool_ready
- pool_data  out  DATA_W  max of current 2x2 window
- pool_idx  out  4  pooled index k = pr*(MAP_W/2)+pc, 0..15
- busy  out  1  high from cycle after start until done
- done  out  1  single-cycle pulse after last output accepted

## Operation
- States: IDLE, RD, LAST, OUT, DONE.
- IDLE: start=1 -> RD, k=0, rd_cnt=0, busy=1.
- Window base for k: (2*pr)*MAP_W + 2*pc; offsets in order 0, 1, MAP_W, MAP_W+1.
- RD (4 cycles, rd_cnt 0..3): ofmd_read=1, read_addr=base+offset[rd_cnt]. At rd_cnt=1 max<=ofmd_data; at rd_cnt=2,3 max<=max(max,ofmd_data). rd_cnt=3 -> LAST.
- LAST: ofmd_read=0; pool_data<=max(max,ofmd_data); pool_idx<=k; pool_valid<=1; -> OUT.
- OUT: hold pool_valid, pool_data, pool_idx stable, no RAM reads, until pool_ready=1. On accept: pool_valid<=0; if k==15 -> DONE else k<=k+1, rd_cnt<=0, -> RD.
- DONE: done=1 one cycle, busy<=0, -> IDLE.
- Comparison unsigned; ties keep either value (identical). No arithmetic beyond compare; addresses never exceed MAP_W*MAP_H-1.
- start while busy: ignored, no effect on k or state.
- The RAM must not be written during a pass; enforced by the top-level sequencer, not checked here.

## Timing
- Reset values: ofmd_read=0, read_addr=0, pool_valid=0, pool_data=0, pool_idx=0, busy=0, done=0, state=IDLE, k=0, max=0.
- rst asserted mid-pass: all outputs return to reset values immediately (asynchronously); the pass is abandoned, no done pulse; a new start is required.
- start sampled at cycle 0 -> first read at cycle 1 -> first pool_valid visible cycle 6.
- With pool_ready held high: one output every 6 cycles (4 RD + LAST + OUT); full pass = 96 cycles, done high at cycle 97, busy low from cycle 98.
- ofmd_read is high only in RD; read_addr holds last value outside RD.
- pool_ready low in OUT stalls indefinitely; no reads issued during stall.
- pool_ready asserted outside OUT has no effect.

## Test plan
- Ascending map data[a]=a, pool_ready=1: outputs k=0..15 = 9,11,13,15,25,27,29,31,41,43,45,47,57,59,61,63; done at cycle 97 after start.
- Descending map data[a]=63-a: max is window offset 0; k=0 -> 63, k=5 -> 45, k=15 -> 9; read_addr sequence for k=0 is 0,1,8,9.
- Backpressure: pool_ready low 10 cycles when pool_idx=5 -> pool_valid, pool_data=27 (ascending map), pool_idx stable; ofmd_read=0 throughout stall; resumes k=6 after accept.
- Ties and full scale: all entries 255 -> all 16 outputs 255; one window with {0,0,0,200} at offset MAP_W+1 -> 200.
- Reset mid-pass: assert rst while pool_idx=7 -> all outputs zero same cycle, no done; subsequent start produces k=0..15 from beginning.
- start pulses while busy (cycles 10 and 50): ignored; output count exactly 16, single done.
